// File: rtl/receiver.sv
// 8N1 UART receive stage: recovers bytes from rx using a 16x-baud clken tick, with a rdy/rdy_clr handshake.
// Optional RECEIVER_MAJORITY_EN: each sample point takes the 2-of-3 vote of the last three clken samples.
module receiver (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       clken,
  input  logic       rdy_clr,
  output logic [7:0] data,
  output logic       rdy,
  output logic       frame_err,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] sync_reg;
  logic       rx_s;
  logic       rx_bit;
  logic [3:0] sample_reg, sample_next;
  logic [2:0] bitpos_reg, bitpos_next;
  logic [7:0] shift_reg, shift_next;
  logic [7:0] data_reg;
  logic       rdy_reg;
  logic       frame_err_reg;
  logic       overrun_reg;
  logic       stop_good;
  logic       stop_bad;

  // rx is asynchronous to clock; idle level is high so the synchronizer resets to 1.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rx};
    end
  end

  assign rx_s = sync_reg[1];

`ifdef RECEIVER_MAJORITY_EN
  logic [1:0] vote_reg;

  // History of the two previous clken samples; the current rx_s is the third voter.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vote_reg <= 2'b11;
    end else if (clken) begin
      vote_reg <= {vote_reg[0], rx_s};
    end
  end

  assign rx_bit = (vote_reg[1] & vote_reg[0]) |
                  (vote_reg[1] & rx_s) |
                  (vote_reg[0] & rx_s);
`else
  assign rx_bit = rx_s;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    sample_next = sample_reg;
    bitpos_next = bitpos_reg;
    shift_next  = shift_reg;
    stop_good   = 1'b0;
    stop_bad    = 1'b0;
    if (clken) begin
      case (state_reg)
        IDLE: begin
          if (!rx_s) begin
            sample_next = 4'd0;
            state_next  = START;
          end
        end
        START: begin
          sample_next = sample_reg + 4'd1;
          // Mid start bit: a line that is high again was only a glitch.
          if (sample_reg == 4'd7) begin
            if (!rx_bit) begin
              sample_next = 4'd0;
              bitpos_next = 3'd0;
              state_next  = DATA;
            end else begin
              state_next = IDLE;
            end
          end
        end
        DATA: begin
          sample_next = sample_reg + 4'd1;
          if (sample_reg == 4'd15) begin
            shift_next[bitpos_reg] = rx_bit;
            if (bitpos_reg == 3'd7) begin
              sample_next = 4'd0;
              state_next  = STOP;
            end else begin
              bitpos_next = bitpos_reg + 3'd1;
            end
          end
        end
        STOP: begin
          sample_next = sample_reg + 4'd1;
          // Leaving at mid stop bit lets a back-to-back start edge be caught.
          if (sample_reg == 4'd15) begin
            stop_good  = rx_bit;
            stop_bad   = ~rx_bit;
            state_next = IDLE;
          end
        end
        default: begin
          state_next = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sample_reg <= 4'd0;
      bitpos_reg <= 3'd0;
      shift_reg  <= 8'h00;
    end else begin
      sample_reg <= sample_next;
      bitpos_reg <= bitpos_next;
      shift_reg  <= shift_next;
    end
  end

  // A completing good byte beats a simultaneous rdy_clr; overrun only latches when unacknowledged.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data_reg      <= 8'h00;
      rdy_reg       <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      if (stop_good) begin
        data_reg      <= shift_reg;
        rdy_reg       <= 1'b1;
        frame_err_reg <= 1'b0;
        if (rdy_clr) begin
          overrun_reg <= 1'b0;
        end else if (rdy_reg) begin
          overrun_reg <= 1'b1;
        end
      end else begin
        if (stop_bad) begin
          frame_err_reg <= 1'b1;
        end
        if (rdy_clr) begin
          rdy_reg     <= 1'b0;
          overrun_reg <= 1'b0;
        end
      end
    end
  end

  assign data      = data_reg;
  assign rdy       = rdy_reg;
  assign frame_err = frame_err_reg;
  assign overrun   = overrun_reg;

endmodule
